uart_threshold_bank: RTL
========================

// Module: uart_threshold_bank
// PURPOSE
//  Byte-command register bank of NUM_CH signed thresholds, set over the UART link.
//  Sits between the uart core (rx byte strobe, tx start/idle handshake) and control logic.
//  Thresholds are exported as one packed bus.
//  Generalises the fixed solar/ambient/geothermal controller:
//   - per-channel step and limits
//   - read-back, restore-default and error commands
//   - multi-byte responses sized from WIDTH
// PARAMETERS
//  NUM_CH    7          number of channels, 1..26 (select chars 'A'..'A'+NUM_CH-1)
//  WIDTH     16         signed threshold width, 2..32
//  STEP_VEC  {7{16'sd1}}    packed NUM_CH*WIDTH, per-channel inc/dec step (>0); ch k at [k*WIDTH+:WIDTH]
//  MIN_VEC   {7{-16'sd12}}  packed per-channel lower limit
//  MAX_VEC   {7{16'sd50}}   packed per-channel upper limit (MIN<=DEF<=MAX)
//  DEF_VEC   {7{16'sd16}}   packed per-channel reset/default value
// PORTS
//  clk        in   1              clock
//  rst        in   1              reset rst, synchronous, active-high; clock clk
//  rx_data    in   8              received byte, valid when rx_valid
//  rx_valid   in   1              one-cycle strobe per received byte
//  tx_ready   in   1              uart transmitter idle
//  tx_start   out  1              one-cycle pulse: send tx_data
//  tx_data    out  8              byte to transmit, held stable while tx_start=1
//  th_flat    out  NUM_CH*WIDTH   all thresholds, ch k at [k*WIDTH+:WIDTH]
//  sel_ch     out  5              currently selected channel index
//  busy       out  1              response in progress; rx bytes are dropped
//  rx_drop    out  1              one-cycle pulse when a byte is dropped (busy)
// BEHAVIOUR
//  Reset (outputs and state)
//   - all channels = DEF, sel_ch=0, tx_start=0, tx_data=0, busy=0, rx_drop=0, FSM=IDLE.
//   - rst mid-response abandons it; no further tx_start is issued.
//  Commands, accepted only in IDLE on rx_valid:
//   - 'A'+k (k<NUM_CH): sel_ch<=k.
//   - 'w': value[sel] += STEP.
//   - 's': value[sel] -= STEP.
//   - 'r': read only.
//   - 'z': value[sel] <= DEF.
//   - any other byte: error.
//  Arithmetic
//   - computed in WIDTH+1 bits, signed, saturating: inc result > MAX -> MAX; dec result < MIN -> MIN.
//   - at a limit the value is unchanged; the response is still sent.
//  Timing
//   - the register/sel update happens on the accepting edge; th_flat/sel_ch show it the next cycle.
//  FSM states: IDLE -> ECHO -> (VAL) -> GUARD -> IDLE
//   - ECHO: wait tx_ready; pulse tx_start with the echo byte.
//     - echo byte = the command byte, or '?' (0x3F) for an error.
//     - select or error: go to GUARD.
//     - w/s/r/z: go to VAL.
//   - VAL: send NB=(WIDTH+7)/8 bytes of value[sel], LSB first, using a byte counter.
//     - each byte waits for tx_ready before its tx_start pulse.
//     - the last byte is sign-extended above WIDTH.
//     - the value is snapshotted when VAL is entered.
//   - Handshake: after every tx_start pulse, tx_ready is ignored for 1 cycle (uart latency). GUARD lasts 1 cycle.
//  Overflow and dropped bytes
//   - busy=1 in every state except IDLE.
//   - rx_valid while busy: byte discarded, rx_drop pulses; state unaffected.
//  Simultaneous events: rx_valid in the same cycle GUARD->IDLE is dropped; it is accepted only when sampled in IDLE.
//  Min response latency: rx_valid at T -> echo tx_start at T+1 if tx_ready=1.
// TESTING
//  1. Reset, 'A','r' (WIDTH=16) -> tx bytes 'A','r',0x10,0x00; th_flat[15:0]=16.
//  2. 'C', then 'w' x40 -> ch2 saturates at 50; final 'w' still echoes 'w',0x32,0x00; other channels stay 16.
//  3. 'B', 's' x30 -> ch1=-12; response after the last 's' is 's',0xF4,0xFF; then 'z' -> 16.
//  4. 'x' and 'A'+NUM_CH -> echo '?' only; th_flat and sel_ch unchanged.
//  5. Hold tx_ready=0 for 100 cycles after 'w':
//     - no tx_start while held; busy=1.
//     - a byte sent during this gets rx_drop and is not executed.
//     - tx_ready=1 -> 3 bytes sent.
//  6. rst asserted after the 2nd tx byte of 'w' on ch0=20:
//     - no further tx_start.
//     - all channels return to 16, sel_ch=0; the next 'r' works.

Source files
------------

// File: rtl/uart_threshold_bank.sv
// Byte-command bank of NUM_CH signed thresholds driven from a UART byte link.
// Ports: clk/rst, rx_data/rx_valid in, tx_ready in, tx_start/tx_data out,
//        th_flat (all thresholds), sel_ch, busy, rx_drop.
module uart_threshold_bank #(
  parameter int NUM_CH = 7,
  parameter int WIDTH  = 16,
  parameter logic [NUM_CH*WIDTH-1:0] STEP_VEC = {7{16'sd1}},
  parameter logic [NUM_CH*WIDTH-1:0] MIN_VEC  = {7{-16'sd12}},
  parameter logic [NUM_CH*WIDTH-1:0] MAX_VEC  = {7{16'sd50}},
  parameter logic [NUM_CH*WIDTH-1:0] DEF_VEC  = {7{16'sd16}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    tx_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [NUM_CH*WIDTH-1:0] th_flat,
  output logic [4:0]              sel_ch,
  output logic                    busy,
  output logic                    rx_drop
);

  localparam int NB = (WIDTH + 7) / 8;
  localparam int SW = NB * 8;
  localparam logic [7:0] CH_LO = 8'h41;
  localparam logic [7:0] CH_HI = 8'(65 + NUM_CH);
  localparam logic [7:0] C_W   = 8'h77;
  localparam logic [7:0] C_S   = 8'h73;
  localparam logic [7:0] C_R   = 8'h72;
  localparam logic [7:0] C_Z   = 8'h7A;
  localparam logic [7:0] C_ERR = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ECHO,
    S_VAL,
    S_GUARD
  } state_t;

  state_t                   state_q;
  logic signed [WIDTH-1:0]  val_q [NUM_CH];
  logic [4:0]               sel_q;
  logic [7:0]               echo_q;
  logic                     need_val_q;
  logic [SW-1:0]            snap_q;
  logic [2:0]               cnt_q;
  logic                     tx_start_q;
  logic [7:0]               tx_data_q;
  logic                     rx_drop_q;

  logic signed [WIDTH-1:0]  cur;
  logic signed [WIDTH-1:0]  stp;
  logic signed [WIDTH-1:0]  lo;
  logic signed [WIDTH-1:0]  hi;
  logic signed [WIDTH-1:0]  df;
  logic signed [WIDTH:0]    sum;
  logic signed [WIDTH:0]    dif;
  logic signed [WIDTH:0]    lo_e;
  logic signed [WIDTH:0]    hi_e;
  logic signed [WIDTH-1:0]  val_d;
  logic                     upd_d;
  logic                     is_sel;
  logic [4:0]               sel_d;
  logic [7:0]               echo_d;
  logic                     need_val_d;

  // Per-channel constants and current value for the selected channel.
  always_comb begin
    cur = '0;
    stp = '0;
    lo  = '0;
    hi  = '0;
    df  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == 5'(k)) begin
        cur = val_q[k];
        stp = STEP_VEC[k*WIDTH +: WIDTH];
        lo  = MIN_VEC[k*WIDTH +: WIDTH];
        hi  = MAX_VEC[k*WIDTH +: WIDTH];
        df  = DEF_VEC[k*WIDTH +: WIDTH];
      end
    end
  end

  // One extra bit keeps the step from wrapping before the limit compare.
  always_comb begin
    sum  = {cur[WIDTH-1], cur} + {stp[WIDTH-1], stp};
    dif  = {cur[WIDTH-1], cur} - {stp[WIDTH-1], stp};
    lo_e = {lo[WIDTH-1], lo};
    hi_e = {hi[WIDTH-1], hi};
  end

  always_comb begin
    is_sel     = (rx_data >= CH_LO) && (rx_data < CH_HI);
    sel_d      = 5'(rx_data - CH_LO);
    upd_d      = 1'b0;
    val_d      = cur;
    echo_d     = rx_data;
    need_val_d = 1'b1;
    unique case (1'b1)
      is_sel: begin
        need_val_d = 1'b0;
      end
      rx_data == C_W: begin
        upd_d = 1'b1;
        val_d = (sum > hi_e) ? hi : sum[WIDTH-1:0];
      end
      rx_data == C_S: begin
        upd_d = 1'b1;
        val_d = (dif < lo_e) ? lo : dif[WIDTH-1:0];
      end
      rx_data == C_Z: begin
        upd_d = 1'b1;
        val_d = df;
      end
      rx_data == C_R: begin
        upd_d = 1'b0;
      end
      default: begin
        need_val_d = 1'b0;
        echo_d     = C_ERR;
      end
    endcase
  end

  // tx_start_q doubles as the one-cycle tx_ready blanking after a send.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int k = 0; k < NUM_CH; k++) begin
        val_q[k] <= DEF_VEC[k*WIDTH +: WIDTH];
      end
      sel_q      <= '0;
      echo_q     <= '0;
      need_val_q <= 1'b0;
      snap_q     <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rx_drop_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      rx_drop_q  <= rx_valid && (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (is_sel) begin
              sel_q <= sel_d;
            end
            for (int k = 0; k < NUM_CH; k++) begin
              if (upd_d && (sel_q == 5'(k))) begin
                val_q[k] <= val_d;
              end
            end
            echo_q     <= echo_d;
            need_val_q <= need_val_d;
            state_q    <= S_ECHO;
          end
        end
        S_ECHO: begin
          if (tx_ready && !tx_start_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= echo_q;
            cnt_q      <= '0;
            snap_q     <= SW'(cur);
            state_q    <= need_val_q ? S_VAL : S_GUARD;
          end
        end
        S_VAL: begin
          if (tx_ready && !tx_start_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= snap_q[7:0];
            snap_q     <= snap_q >> 8;
            if (cnt_q == 3'(NB - 1)) begin
              state_q <= S_GUARD;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_GUARD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_th
    assign th_flat[k*WIDTH +: WIDTH] = val_q[k];
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sel_ch   = sel_q;
  assign busy     = (state_q != S_IDLE);
  assign rx_drop  = rx_drop_q;

endmodule
